// File: rtl/spi_frame_master_if.sv
// spi_frame_master_if
//   Host-side bundle of the SPI frame master: request/handshake, received frame
//   and the serial pins (load/sclk/sdi/sdo).
//   master modport : the frame master (drives busy/done/rx_data/sclk/sdi/load)
//   slave modport  : the host + target side (drives start/tx_data/sdo)
interface spi_frame_master_if #(
   parameter int FRAME_BITS = 64
);
   logic                  start;
   logic [FRAME_BITS-1:0] tx_data;
   logic                  busy;
   logic                  done;
   logic [FRAME_BITS-1:0] rx_data;
   logic                  sclk;
   logic                  sdi;
   logic                  load;
   logic                  sdo;

   modport master (
      input  start, tx_data, sdo,
      output busy, done, rx_data, sclk, sdi, load
   );

   modport slave (
      output start, tx_data, sdo,
      input  busy, done, rx_data, sclk, sdi, load
   );
endinterface

// File: rtl/spi_frame_master.sv
// spi_frame_master
//   SPI initiator: shifts a FRAME_BITS-wide frame MSB-first onto sdi/sclk,
//   framed by load, and captures the target's sdo stream into rx_data.
//   Frame = SETUP (sclk low) then FRAME_BITS x (HIGH, LOW), each phase CLK_DIV
//   clks; done pulses CLK_DIV*(1+2*FRAME_BITS) clks after the accepting edge.
// Ports
//   clk    : system clock, posedge
//   reset  : asynchronous, active-low
//   bus    : spi_frame_master_if.master
//            start/tx_data in, busy/done/rx_data out,
//            sclk/sdi/load out, sdo in
// Configuration macro
//   SPI_SDO_SYNC_EN : sdo goes through a 2-flop synchronizer and is sampled
//                     on the last clk edge of HIGH instead of the edge that
//                     raises sclk (needs CLK_DIV >= 3).
module spi_frame_master #(
   parameter int FRAME_BITS = 64,
   parameter int CLK_DIV    = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   spi_frame_master_if.master     bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SETUP = 2'd1;
   localparam logic [1:0] HIGH  = 2'd2;
   localparam logic [1:0] LOW   = 2'd3;

   localparam int BW = $clog2(FRAME_BITS);
   localparam int PW = $clog2(CLK_DIV) + 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

   logic [1:0]            state;
   logic [PW-1:0]         phase;
   logic [BW-1:0]         bit_cnt;
   logic [FRAME_BITS-1:0] tx_sr;
   logic [FRAME_BITS-1:0] rx_sr;
   logic [FRAME_BITS-1:0] rx_q;
   logic                  sclk_q, sdi_q, load_q, busy_q, done_q;
   logic                  ph_end;
   logic                  sample;
   logic                  sdo_bit;

   assign ph_end = (phase == PH_LAST);

`ifdef SPI_SDO_SYNC_EN
   logic [1:0] sdo_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sdo_sync <= '0;
      else        sdo_sync <= {sdo_sync[0], bus.sdo};
   end

   // Synchronizer adds two clks, so sample as late as possible in HIGH.
   assign sdo_bit = sdo_sync[1];
   assign sample  = (state == HIGH) && ph_end;
`else
   // Sample on the edge that raises sclk: end of SETUP, or end of any LOW
   // that is followed by another HIGH.
   assign sdo_bit = bus.sdo;
   assign sample  = ph_end && ((state == SETUP) ||
                               ((state == LOW) && (bit_cnt != BIT_LAST)));
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         phase   <= '0;
         bit_cnt <= '0;
         tx_sr   <= '0;
         rx_sr   <= '0;
         rx_q    <= '0;
         sclk_q  <= 1'b0;
         sdi_q   <= 1'b0;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (sample) rx_sr <= {rx_sr[FRAME_BITS-2:0], sdo_bit};
         case (state)
            IDLE: begin
               if (bus.start) begin
                  tx_sr   <= bus.tx_data;
                  sdi_q   <= bus.tx_data[FRAME_BITS-1];
                  load_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  sclk_q  <= 1'b0;
                  bit_cnt <= '0;
                  phase   <= '0;
                  state   <= SETUP;
               end
            end
            SETUP: begin
               if (ph_end) begin
                  phase  <= '0;
                  sclk_q <= 1'b1;
                  state  <= HIGH;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            HIGH: begin
               if (ph_end) begin
                  phase  <= '0;
                  sclk_q <= 1'b0;
                  // Next bit goes out while sclk is low; after the last bit
                  // this presents a shifted-in zero, harmless until IDLE.
                  tx_sr  <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                  sdi_q  <= tx_sr[FRAME_BITS-2];
                  state  <= LOW;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: begin // LOW
               if (ph_end) begin
                  phase <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     load_q <= 1'b0;
                     busy_q <= 1'b0;
                     sdi_q  <= 1'b0;
                     done_q <= 1'b1;
                     rx_q   <= rx_sr;
                     state  <= IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     sclk_q  <= 1'b1;
                     state   <= HIGH;
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.sclk    = sclk_q;
   assign bus.sdi     = sdi_q;
   assign bus.load    = load_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_q;
endmodule
